// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: valid/ready push into a power-of-two FIFO,
// 8N/8E/8O framing, LSB first, 1 or 2 stop bits, frames back-to-back when queued.
module uart_tx #(
  parameter int unsigned CLOCK_RATE = 27_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          i_CLK,
  input  logic                          i_RST_N,
  input  logic                          i_VALID,
  input  logic [7:0]                    i_DATA,
  output logic                          o_READY,
  output logic                          o_TX,
  output logic                          o_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   o_COUNT
);

  localparam int unsigned DIV = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned BW  = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx: CLOCK_RATE/BAUD_RATE must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end
  if (PARITY > 2) begin : g_par_chk
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_stop_chk
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_data;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic            r_stop;
  logic            r_tx;
  logic            r_busy;

  logic            w_push;
  logic            w_pop;
  logic            w_not_empty;
  logic            w_baud_done;
  logic            w_last_stop;
  logic            w_par_bit;
  logic [BW-1:0]   w_baud_next;
  logic [2:0]      w_bit_next;
  logic            w_stop_next;
  logic            w_tx_next;
  logic            w_busy_next;

  assign o_READY     = (r_count != CW'(FIFO_DEPTH));
  assign o_TX        = r_tx;
  assign o_BUSY      = r_busy;
  assign o_COUNT     = r_count;
  assign w_push      = i_VALID && o_READY;
  assign w_not_empty = (r_count != '0);
  assign w_baud_done = (r_baud == BW'(DIV - 1));
  assign w_last_stop = (STOP_BITS == 1) || r_stop;
  assign w_par_bit   = (PARITY == 1) ? ~^r_data : ^r_data;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // A pop happens only when a frame is about to start (from idle or straight out of the last stop cycle)
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_not_empty) begin
          w_state_next = S_START;
          w_pop        = 1'b1;
        end
      end
      S_START: if (w_baud_done) w_state_next = S_DATA;
      S_DATA: begin
        if (w_baud_done && (r_bit == 3'd7)) w_state_next = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR:   if (w_baud_done) w_state_next = S_STOP;
      S_STOP: begin
        if (w_baud_done && w_last_stop) begin
          if (w_not_empty) begin
            w_state_next = S_START;
            w_pop        = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Line level is chosen from the state being entered so o_TX changes on the bit boundary edge
  always_comb begin
    w_baud_next = (r_state == S_IDLE || w_baud_done) ? '0 : r_baud + BW'(1);
    w_bit_next  = r_bit;
    w_stop_next = 1'b0;
    w_tx_next   = 1'b1;
    if (r_state == S_DATA && w_baud_done) w_bit_next = r_bit + 3'd1;
    if (r_state == S_STOP) w_stop_next = w_baud_done ? ~r_stop : r_stop;
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = r_data[w_bit_next];
      S_PAR:   w_tx_next = w_par_bit;
      default: w_tx_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_stop   <= 1'b0;
      r_data   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= w_busy_next;
      r_baud <= w_baud_next;
      r_bit  <= w_bit_next;
      r_stop <= w_stop_next;
      if (w_pop) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= i_DATA;
  end

endmodule
